// File: rtl/sdram_req_queue.sv
// sdram_req_queue: client request FIFO in front of sdram_burst port 0.
// Issues one command at a time, returns read bursts, and watches for hangs.
module sdram_req_queue #(
    parameter int ADDR_WIDTH     = 25,
    parameter int DEPTH          = 4,
    parameter int Q_WIDTH        = 128,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [15:0]           req_data,
    input  logic [1:0]            req_byte_en,
    output logic                  rd_valid,
    output logic [Q_WIDTH-1:0]    rd_data,
    output logic                  cmd_done,
    output logic                  timeout_err,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] p0_addr,
    output logic [15:0]           p0_data,
    output logic [1:0]            p0_byte_en,
    output logic                  p0_wr_req,
    output logic                  p0_rd_req,
    input  logic                  p0_available,
    input  logic                  p0_ready,
    input  logic [Q_WIDTH-1:0]    p0_q
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES);

    typedef struct packed {
        logic                  write;
        logic [ADDR_WIDTH-1:0] addr;
        logic [15:0]           data;
        logic [1:0]            byte_en;
    } entry_t;

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    entry_t           mem [DEPTH];
    entry_t           head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    state_t           state;
    logic             op_read;
    logic [WD_W-1:0]  watchdog;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign req_ready = ~full;
    assign push      = req_valid & ~full;
    assign pop       = (state == S_IDLE) & ~empty & p0_available;
    assign busy      = ~empty | (state == S_WAIT);
    assign head      = mem[rd_ptr];

    // Entry storage; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {req_write, req_addr, req_data, req_byte_en};
        end
    end

    // Pointer and occupancy bookkeeping; simultaneous push/pop keeps count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (!push && pop) count <= count - CNT_W'(1);
        end
    end

    // Issue/wait FSM with all controller and client outputs registered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            op_read     <= 1'b0;
            watchdog    <= '0;
            p0_addr     <= '0;
            p0_data     <= '0;
            p0_byte_en  <= '0;
            p0_wr_req   <= 1'b0;
            p0_rd_req   <= 1'b0;
            cmd_done    <= 1'b0;
            rd_valid    <= 1'b0;
            rd_data     <= '0;
            timeout_err <= 1'b0;
        end else begin
            p0_wr_req <= 1'b0;
            p0_rd_req <= 1'b0;
            cmd_done  <= 1'b0;
            rd_valid  <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (pop) begin
                        p0_addr    <= head.addr;
                        p0_data    <= head.data;
                        p0_byte_en <= head.byte_en;
                        p0_wr_req  <= head.write;
                        p0_rd_req  <= ~head.write;
                        op_read    <= ~head.write;
                        watchdog   <= '0;
                        state      <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (p0_ready) begin
                        cmd_done <= 1'b1;
                        if (op_read) begin
                            rd_valid <= 1'b1;
                            rd_data  <= p0_q;
                        end
                        state <= S_IDLE;
                    end else if (watchdog == WD_W'(TIMEOUT_CYCLES - 1)) begin
                        timeout_err <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        watchdog <= watchdog + WD_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_req_queue.sv
// Directed testbench for sdram_req_queue.
// Drives a hand-scripted controller and checks hand-computed values.
module tb_sdram_req_queue;

    localparam int AW = 25;
    localparam int QW = 128;
    localparam logic [QW-1:0] RD_Q =
        128'h0007_0006_0005_0004_0003_0002_0001_0000;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [15:0]   req_data;
    logic [1:0]    req_byte_en;
    logic          rd_valid;
    logic [QW-1:0] rd_data;
    logic          cmd_done;
    logic          timeout_err;
    logic          busy;
    logic [AW-1:0] p0_addr;
    logic [15:0]   p0_data;
    logic [1:0]    p0_byte_en;
    logic          p0_wr_req;
    logic          p0_rd_req;
    logic          p0_available;
    logic          p0_ready;
    logic [QW-1:0] p0_q;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    sdram_req_queue #(
        .ADDR_WIDTH(AW),
        .DEPTH(4),
        .Q_WIDTH(QW),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_addr(req_addr),
        .req_data(req_data),
        .req_byte_en(req_byte_en),
        .rd_valid(rd_valid),
        .rd_data(rd_data),
        .cmd_done(cmd_done),
        .timeout_err(timeout_err),
        .busy(busy),
        .p0_addr(p0_addr),
        .p0_data(p0_data),
        .p0_byte_en(p0_byte_en),
        .p0_wr_req(p0_wr_req),
        .p0_rd_req(p0_rd_req),
        .p0_available(p0_available),
        .p0_ready(p0_ready),
        .p0_q(p0_q)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n      = 1'b0;
        req_valid    = 1'b1;
        req_write    = 1'b1;
        req_addr     = 25'h1;
        req_data     = 16'hffff;
        req_byte_en  = 2'b11;
        p0_available = 1'b1;
        p0_ready     = 1'b0;
        p0_q         = '0;
        repeat (3) tick();
        total_cnt++;
        if (req_ready !== 1'b1) $display("FAIL rst_ready: got %b expected 1", req_ready);
        else pass_cnt++;
        total_cnt++;
        if ({p0_wr_req, p0_rd_req, cmd_done, rd_valid, timeout_err, busy} !== 6'b0)
            $display("FAIL rst_flags: got %b expected 000000",
                     {p0_wr_req, p0_rd_req, cmd_done, rd_valid, timeout_err, busy});
        else pass_cnt++;
        total_cnt++;
        if ({p0_addr, p0_data, p0_byte_en} !== '0 || rd_data !== '0)
            $display("FAIL rst_data: got %h/%h expected 0/0",
                     {p0_addr, p0_data, p0_byte_en}, rd_data);
        else pass_cnt++;
        req_valid = 1'b0;
        reset_n   = 1'b1;
        tick();
        total_cnt++;
        if (busy !== 1'b0 || p0_wr_req !== 1'b0)
            $display("FAIL rst_no_push: got busy=%b wr=%b expected 0 0", busy, p0_wr_req);
        else pass_cnt++;
    endtask

    task automatic test_single_write();
        p0_available = 1'b1;
        req_valid    = 1'b1;
        req_write    = 1'b1;
        req_addr     = 25'h0322020;
        req_data     = 16'h1234;
        req_byte_en  = 2'b11;
        tick();
        req_valid = 1'b0;
        total_cnt++;
        if (p0_wr_req !== 1'b0 || busy !== 1'b1)
            $display("FAIL wr_no_bypass: got wr=%b busy=%b expected 0 1", p0_wr_req, busy);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (p0_wr_req !== 1'b1 || p0_rd_req !== 1'b0)
            $display("FAIL wr_issue: got wr=%b rd=%b expected 1 0", p0_wr_req, p0_rd_req);
        else pass_cnt++;
        total_cnt++;
        if (p0_addr !== 25'h0322020 || p0_data !== 16'h1234 || p0_byte_en !== 2'b11)
            $display("FAIL wr_fields: got %h %h %b expected 0322020 1234 11",
                     p0_addr, p0_data, p0_byte_en);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (p0_wr_req !== 1'b0 || p0_addr !== 25'h0322020 || p0_data !== 16'h1234)
            $display("FAIL wr_hold: got wr=%b addr=%h data=%h expected 0 0322020 1234",
                     p0_wr_req, p0_addr, p0_data);
        else pass_cnt++;
        repeat (3) tick();
        p0_ready = 1'b1;
        total_cnt++;
        if (cmd_done !== 1'b0) $display("FAIL wr_early_done: got %b expected 0", cmd_done);
        else pass_cnt++;
        tick();
        p0_ready = 1'b0;
        total_cnt++;
        if (cmd_done !== 1'b1 || rd_valid !== 1'b0)
            $display("FAIL wr_done: got done=%b rdv=%b expected 1 0", cmd_done, rd_valid);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (cmd_done !== 1'b0 || busy !== 1'b0)
            $display("FAIL wr_after: got done=%b busy=%b expected 0 0", cmd_done, busy);
        else pass_cnt++;
    endtask

    task automatic test_read_return();
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 25'h0000010;
        tick();
        req_valid = 1'b0;
        tick();
        total_cnt++;
        if (p0_rd_req !== 1'b1 || p0_wr_req !== 1'b0 || p0_addr !== 25'h10)
            $display("FAIL rd_issue: got rd=%b wr=%b addr=%h expected 1 0 10",
                     p0_rd_req, p0_wr_req, p0_addr);
        else pass_cnt++;
        p0_q     = RD_Q;
        p0_ready = 1'b1;
        tick();
        p0_ready = 1'b0;
        p0_q     = '0;
        total_cnt++;
        if (rd_valid !== 1'b1 || cmd_done !== 1'b1)
            $display("FAIL rd_pulse: got rdv=%b done=%b expected 1 1", rd_valid, cmd_done);
        else pass_cnt++;
        total_cnt++;
        if (rd_data !== RD_Q) $display("FAIL rd_data: got %h expected %h", rd_data, RD_Q);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (rd_valid !== 1'b0 || rd_data !== RD_Q)
            $display("FAIL rd_hold: got rdv=%b data=%h expected 0 %h", rd_valid, rd_data, RD_Q);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        p0_available = 1'b0;
        for (int i = 0; i < 5; i++) begin
            req_valid   = 1'b1;
            req_write   = 1'b1;
            req_addr    = AW'(32'h100 + i);
            req_data    = 16'(32'hA000 + i);
            req_byte_en = i[1:0];
            tick();
            total_cnt++;
            if (req_ready !== (i < 3))
                $display("FAIL bp_ready%0d: got %b expected %b", i, req_ready, (i < 3));
            else pass_cnt++;
        end
        req_valid = 1'b0;
        total_cnt++;
        if (busy !== 1'b1 || p0_wr_req !== 1'b0)
            $display("FAIL bp_hold: got busy=%b wr=%b expected 1 0", busy, p0_wr_req);
        else pass_cnt++;
        p0_available = 1'b1;
        for (int i = 0; i < 4; i++) begin
            int n = 0;
            while (p0_wr_req !== 1'b1 && n < 8) begin
                tick();
                n++;
            end
            total_cnt++;
            if (p0_wr_req !== 1'b1 || p0_addr !== AW'(32'h100 + i) ||
                p0_data !== 16'(32'hA000 + i) || p0_byte_en !== i[1:0])
                $display("FAIL bp_issue%0d: got wr=%b addr=%h data=%h be=%b expected 1 %h %h %b",
                         i, p0_wr_req, p0_addr, p0_data, p0_byte_en,
                         AW'(32'h100 + i), 16'(32'hA000 + i), i[1:0]);
            else pass_cnt++;
            if (i == 0) begin
                total_cnt++;
                if (req_ready !== 1'b1)
                    $display("FAIL bp_ready_pop: got %b expected 1", req_ready);
                else pass_cnt++;
            end
            p0_ready = 1'b1;
            tick();
            p0_ready = 1'b0;
            total_cnt++;
            if (cmd_done !== 1'b1) $display("FAIL bp_done%0d: got %b expected 1", i, cmd_done);
            else pass_cnt++;
        end
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL bp_idle: got busy=%b expected 0", busy);
        else pass_cnt++;
        begin
            int seen = 0;
            repeat (4) begin
                tick();
                if (p0_wr_req || p0_rd_req) seen++;
            end
            total_cnt++;
            if (seen !== 0) $display("FAIL bp_fifth_dropped: got %0d issues expected 0", seen);
            else pass_cnt++;
        end
    endtask

    task automatic test_timeout();
        int n = 0;
        p0_available = 1'b0;
        req_valid    = 1'b1;
        req_write    = 1'b0;
        req_addr     = 25'h200;
        tick();
        req_write = 1'b1;
        req_addr  = 25'h201;
        req_data  = 16'h5a5a;
        tick();
        req_valid    = 1'b0;
        p0_available = 1'b1;
        while (p0_rd_req !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        total_cnt++;
        if (p0_rd_req !== 1'b1 || p0_addr !== 25'h200)
            $display("FAIL to_issue: got rd=%b addr=%h expected 1 200", p0_rd_req, p0_addr);
        else pass_cnt++;
        repeat (15) tick();
        total_cnt++;
        if (timeout_err !== 1'b0) $display("FAIL to_early: got %b expected 0", timeout_err);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (timeout_err !== 1'b1 || cmd_done !== 1'b0 || rd_valid !== 1'b0)
            $display("FAIL to_set: got err=%b done=%b rdv=%b expected 1 0 0",
                     timeout_err, cmd_done, rd_valid);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (p0_wr_req !== 1'b1 || p0_addr !== 25'h201 || timeout_err !== 1'b1)
            $display("FAIL to_next: got wr=%b addr=%h err=%b expected 1 201 1",
                     p0_wr_req, p0_addr, timeout_err);
        else pass_cnt++;
        p0_ready = 1'b1;
        tick();
        p0_ready = 1'b0;
        total_cnt++;
        if (cmd_done !== 1'b1 || timeout_err !== 1'b1)
            $display("FAIL to_sticky: got done=%b err=%b expected 1 1", cmd_done, timeout_err);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_op();
        int n = 0;
        int seen = 0;
        p0_available = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_valid = 1'b1;
            req_write = 1'b1;
            req_addr  = AW'(32'h300 + i);
            tick();
        end
        req_valid    = 1'b0;
        p0_available = 1'b1;
        while (p0_wr_req !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        total_cnt++;
        if (p0_wr_req !== 1'b1 || p0_addr !== 25'h300 || busy !== 1'b1)
            $display("FAIL mr_issue: got wr=%b addr=%h busy=%b expected 1 300 1",
                     p0_wr_req, p0_addr, busy);
        else pass_cnt++;
        reset_n = 1'b0;
        #1;
        total_cnt++;
        if (busy !== 1'b0 || req_ready !== 1'b1 || timeout_err !== 1'b0 ||
            p0_wr_req !== 1'b0 || p0_addr !== '0)
            $display("FAIL mr_async: got busy=%b rdy=%b err=%b wr=%b addr=%h expected 0 1 0 0 0",
                     busy, req_ready, timeout_err, p0_wr_req, p0_addr);
        else pass_cnt++;
        tick();
        reset_n  = 1'b1;
        p0_ready = 1'b1;
        tick();
        p0_ready = 1'b0;
        total_cnt++;
        if (cmd_done !== 1'b0 || rd_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL mr_ignore: got done=%b rdv=%b busy=%b expected 0 0 0",
                     cmd_done, rd_valid, busy);
        else pass_cnt++;
        repeat (4) begin
            tick();
            if (p0_wr_req || p0_rd_req || cmd_done) seen++;
        end
        total_cnt++;
        if (seen !== 0 || busy !== 1'b0)
            $display("FAIL mr_empty: got events=%0d busy=%b expected 0 0", seen, busy);
        else pass_cnt++;
    endtask

    initial begin
        reset_n      = 1'b0;
        req_valid    = 1'b0;
        req_write    = 1'b0;
        req_addr     = '0;
        req_data     = '0;
        req_byte_en  = '0;
        p0_available = 1'b0;
        p0_ready     = 1'b0;
        p0_q         = '0;
        test_reset();
        test_single_write();
        test_read_return();
        test_backpressure();
        test_timeout();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule

// File: doc/sdram_req_queue.md
Name: sdram_req_queue

Overview:
- Client-side request queue that sits directly upstream of the sdram_burst controller port 0.
- Accepts read/write requests from a client over a valid/ready handshake and buffers them in a small FIFO.
- Issues requests one at a time to the controller using its p0_available/p0_req/p0_ready protocol.
- Returns captured 128-bit burst read data to the client, and flags controller hangs with a watchdog.

Parameters:
- ADDR_WIDTH, 25, word address width; matches controller p0_addr.
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- Q_WIDTH, 128, controller burst read data width.
- TIMEOUT_CYCLES, 1024, maximum cycles in WAIT before error; minimum 2.

Ports:
- clk  in  1  system clock; same clock as the controller.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  client request valid.
- req_ready  out  1  queue can accept a request; equals ~full.
- req_write  in  1  1=write, 0=read.
- req_addr  in  ADDR_WIDTH  word address.
- req_data  in  16  write data.
- req_byte_en  in  2  write byte enables.
- rd_valid  out  1  one-cycle pulse; rd_data valid.
- rd_data  out  Q_WIDTH  captured burst read data.
- cmd_done  out  1  one-cycle pulse on completion of any command.
- timeout_err  out  1  sticky watchdog error flag.
- busy  out  1  FIFO non-empty or command outstanding.
- p0_addr  out  ADDR_WIDTH  to controller.
- p0_data  out  16  to controller.
- p0_byte_en  out  2  to controller.
- p0_wr_req  out  1  one-cycle write request pulse.
- p0_rd_req  out  1  one-cycle read request pulse.
- p0_available  in  1  controller idle and able to accept.
- p0_ready  in  1  controller completion pulse; p0_q valid for reads.
- p0_q  in  Q_WIDTH  controller read data.

Behaviour:
- Reset state (async on reset_n low): every output 0, except req_ready=1. FIFO empty, FSM IDLE, watchdog 0, timeout_err 0.
- FIFO entry: {write, addr, data, byte_en}.
  - Push when req_valid & req_ready.
  - Pop on issue.
  - Push and pop in the same cycle: count unchanged.
  - req_ready=0 when count==DEPTH; req_valid while full is ignored.
- No bypass: a request pushed at edge N is issued no earlier than edge N+1, so p0_*_req is high in the cycle after the push.
- FSM has two states:
  - IDLE: if FIFO non-empty and p0_available=1, pop the head and register it onto p0_addr/p0_data/p0_byte_en. Assert exactly one of p0_wr_req/p0_rd_req for exactly one cycle. Record op type, clear watchdog, go to WAIT.
  - WAIT: p0_addr/data/byte_en held stable; p0_available ignored. Watchdog increments each cycle.
    - On p0_ready: assert cmd_done for one cycle (registered, the cycle after p0_ready was sampled). If the op was a read, capture p0_q into rd_data and pulse rd_valid in that same cycle. Go to IDLE.
    - If watchdog reaches TIMEOUT_CYCLES-1 without p0_ready: set timeout_err, go to IDLE, no cmd_done. The command is dropped.
  - p0_ready seen in IDLE is ignored.
- Back-to-back issue: from IDLE re-entry, the next issue can occur the following edge if p0_available=1. Minimum spacing between req pulses is 2 cycles after p0_ready.
- rd_data holds its last value until the next read completes.
- timeout_err clears only on reset.
- busy = (count!=0) | (state==WAIT).
- Reset mid-WAIT: the outstanding command is abandoned, queued entries are lost, and the outputs return to reset values immediately.
- p0 write/read requests are never asserted together; p0 outputs are fully registered.

Test Plan:
- Reset: hold reset_n=0 with p0_available=1 and req_valid=1 -> req_ready=1, all other outputs 0, no push.
- Single write: push write addr=0x0322020, data=0x1234, be=2'b11 at edge N; controller available -> p0_wr_req high only in cycle N+1 with those values held. p0_ready 5 cycles later -> cmd_done pulse next cycle, rd_valid stays 0.
- Read return: push read addr=0x0000010; model returns p0_q=128'h0007_0006_..._0000 on p0_ready -> rd_valid pulse with rd_data equal to that value, cmd_done coincident.
- Full/backpressure: p0_available=0, push 5 requests -> req_ready drops after 4th, 5th not accepted. Raise p0_available -> 4 commands issued in push order, req_ready returns after first pop, busy drops after last cmd_done.
- Timeout: TIMEOUT_CYCLES=16, never assert p0_ready -> timeout_err set 16 cycles after issue, FSM issues next queued entry, timeout_err stays set.
- Reset mid-operation: assert reset_n=0 while in WAIT with 2 entries queued, then p0_ready arrives -> no cmd_done/rd_valid, queue empty, busy=0.
